// File: rtl/freecell_pkg.sv
// rtl/freecell_pkg.sv - card, locus and error-code definitions shared by the FreeCell engine
package freecell_pkg;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    localparam logic [1:0] SUIT_H = 2'd0;
    localparam logic [1:0] SUIT_D = 2'd1;
    localparam logic [1:0] SUIT_S = 2'd2;
    localparam logic [1:0] SUIT_C = 2'd3;

    localparam logic [3:0] RANK_ACE  = 4'd1;
    localparam logic [3:0] RANK_KING = 4'd13;

    localparam logic [2:0] ERR_OK        = 3'd0;
    localparam logic [2:0] ERR_BAD_LOC   = 3'd1;
    localparam logic [2:0] ERR_SRC_EMPTY = 3'd2;
    localparam logic [2:0] ERR_DST_FULL  = 3'd3;
    localparam logic [2:0] ERR_RULE      = 3'd4;
    localparam logic [2:0] ERR_SAME      = 3'd5;

    typedef enum logic [1:0] {LOC_COL, LOC_FREE, LOC_HOME, LOC_BAD} loc_kind_e;

    typedef struct packed {
        loc_kind_e  kind;
        logic [3:0] idx;
    } loc_t;

    function automatic logic is_red(input card_t c);
        return (c.suit == SUIT_H) || (c.suit == SUIT_D);
    endfunction

    // Loci are packed as columns, then free cells, then the four homes in suit order.
    function automatic loc_t decode_loc(input int code, input int ncols, input int nfree);
        loc_t l;
        l.kind = LOC_BAD;
        l.idx  = 4'd0;
        if (code < ncols) begin
            l.kind = LOC_COL;
            l.idx  = 4'(code);
        end else if (code < ncols + nfree) begin
            l.kind = LOC_FREE;
            l.idx  = 4'(code - ncols);
        end else if (code < ncols + nfree + 4) begin
            l.kind = LOC_HOME;
            l.idx  = 4'(code - ncols - nfree);
        end
        return l;
    endfunction

endpackage

// File: rtl/freecell_column.sv
// rtl/freecell_column.sv - one tableau column, a cleared-on-pop LIFO of cards
module freecell_column
    import freecell_pkg::*;
#(
    parameter int DEPTH = 20,
    localparam int HW = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  card_t         din_i,
    output card_t         top_o,
    output logic [HW-1:0] height_o,
    output logic          full_o,
    output logic          empty_o
);

    card_t         mem_q [DEPTH];
    logic [HW-1:0] height_q;

    assign height_o = height_q;
    assign full_o   = (height_q == HW'(DEPTH));
    assign empty_o  = (height_q == '0);

    always_comb begin
        top_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (height_q == HW'(i + 1)) top_o = mem_q[i];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            height_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i && !full_o) begin
            for (int i = 0; i < DEPTH; i++)
                if (height_q == HW'(i)) mem_q[i] <= din_i;
            height_q <= height_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            for (int i = 0; i < DEPTH; i++)
                if (height_q == HW'(i + 1)) mem_q[i] <= '0;
            height_q <= height_q - 1'b1;
        end
    end

endmodule

// File: rtl/freecell_engine.sv
// rtl/freecell_engine.sv - FreeCell board state with a validated single-card move pipeline
module freecell_engine
    import freecell_pkg::*;
#(
    parameter int NUM_COLS  = 8,
    parameter int COL_DEPTH = 20,
    parameter int NUM_FREE  = 4,
    parameter int LOC_W     = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [2:0]       load_col,
    input  logic [5:0]       load_card,
    output logic             load_ready,
    input  logic             move_valid,
    input  logic [LOC_W-1:0] move_src,
    input  logic [LOC_W-1:0] move_dst,
    output logic             move_ready,
    output logic             done,
    output logic             move_ok,
    output logic [2:0]       err_code,
    output logic [15:0]      move_count,
    output logic             win
);

    localparam int NF = (NUM_FREE > 0) ? NUM_FREE : 1;
    localparam int HW = $clog2(COL_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CHECK, S_COMMIT} state_e;

    state_e           state_q;
    logic [LOC_W-1:0] src_q, dst_q;
    card_t            src_card_q;
    logic             done_q, ok_q, ready_q, win_q, win_d;
    logic [2:0]       err_q;
    logic [15:0]      count_q;
    card_t            free_q [NF];
    card_t            free_d [NF];
    logic [3:0]       home_q [4];
    logic [3:0]       home_d [4];

    card_t                col_top    [NUM_COLS];
    logic [HW-1:0]        col_height [NUM_COLS];
    logic [NUM_COLS-1:0]  col_full, col_empty, col_push, col_pop;
    card_t                col_din;

    for (genvar g = 0; g < NUM_COLS; g++) begin : gen_col
        freecell_column #(.DEPTH(COL_DEPTH)) u_col (
            .clock    (clock),
            .reset_n  (reset_n),
            .push_i   (col_push[g]),
            .pop_i    (col_pop[g]),
            .din_i    (col_din),
            .top_o    (col_top[g]),
            .height_o (col_height[g]),
            .full_o   (col_full[g]),
            .empty_o  (col_empty[g])
        );
    end

    loc_t       src_l, dst_l;
    card_t      fetch_card, dst_top;
    logic       dst_is_empty, dst_is_full, rule_ok, commit;
    logic [3:0] dst_home_rank;
    logic [2:0] err_c;

    assign commit = (state_q == S_COMMIT) && ok_q;

    always_comb begin
        src_l         = decode_loc(int'(src_q), NUM_COLS, NUM_FREE);
        dst_l         = decode_loc(int'(dst_q), NUM_COLS, NUM_FREE);
        fetch_card    = '0;
        dst_top       = '0;
        dst_is_empty  = 1'b1;
        dst_is_full   = 1'b0;
        dst_home_rank = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (src_l.kind == LOC_COL && src_l.idx == 4'(i)) fetch_card = col_top[i];
            if (dst_l.kind == LOC_COL && dst_l.idx == 4'(i)) begin
                dst_top      = col_top[i];
                dst_is_empty = col_empty[i];
                dst_is_full  = (col_height[i] == HW'(COL_DEPTH));
            end
        end
        for (int i = 0; i < NUM_FREE; i++) begin
            if (src_l.kind == LOC_FREE && src_l.idx == 4'(i)) fetch_card = free_q[i];
            if (dst_l.kind == LOC_FREE && dst_l.idx == 4'(i)) dst_is_full = (free_q[i].rank != 4'd0);
        end
        for (int i = 0; i < 4; i++)
            if (dst_l.kind == LOC_HOME && dst_l.idx == 4'(i)) dst_home_rank = home_q[i];

        rule_ok = 1'b1;
        case (dst_l.kind)
            LOC_COL: if (!dst_is_empty)
                rule_ok = (is_red(src_card_q) != is_red(dst_top)) &&
                          (src_card_q.rank == dst_top.rank - 4'd1);
            // A full home expects rank 14, which no card carries.
            LOC_HOME: rule_ok = (src_card_q.suit == dst_l.idx[1:0]) &&
                                (src_card_q.rank == ((dst_home_rank == 4'd0) ? RANK_ACE
                                                                             : dst_home_rank + 4'd1));
            default: ;
        endcase

        if (src_q == dst_q)                                       err_c = ERR_SAME;
        else if (src_l.kind inside {LOC_BAD, LOC_HOME} || dst_l.kind == LOC_BAD) err_c = ERR_BAD_LOC;
        else if (src_card_q.rank == 4'd0)                         err_c = ERR_SRC_EMPTY;
        else if (dst_is_full)                                     err_c = ERR_DST_FULL;
        else if (!rule_ok)                                        err_c = ERR_RULE;
        else                                                      err_c = ERR_OK;
    end

    always_comb begin
        col_din  = commit ? src_card_q : card_t'(load_card);
        col_push = '0;
        col_pop  = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (state_q == S_IDLE && load_valid && load_col == 3'(i) && !col_full[i]) col_push[i] = 1'b1;
            if (commit && dst_l.kind == LOC_COL && dst_l.idx == 4'(i)) col_push[i] = 1'b1;
            if (commit && src_l.kind == LOC_COL && src_l.idx == 4'(i)) col_pop[i]  = 1'b1;
        end
    end

    always_comb begin
        free_d = free_q;
        home_d = home_q;
        if (commit) begin
            for (int i = 0; i < NUM_FREE; i++) begin
                if (src_l.kind == LOC_FREE && src_l.idx == 4'(i)) free_d[i] = '0;
                if (dst_l.kind == LOC_FREE && dst_l.idx == 4'(i)) free_d[i] = src_card_q;
            end
            for (int i = 0; i < 4; i++)
                if (dst_l.kind == LOC_HOME && dst_l.idx == 4'(i)) home_d[i] = src_card_q.rank;
        end
        win_d = win_q || (home_d[SUIT_H] == RANK_KING && home_d[SUIT_D] == RANK_KING &&
                          home_d[SUIT_S] == RANK_KING && home_d[SUIT_C] == RANK_KING);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NF; i++) free_q[i] <= '0;
            for (int i = 0; i < 4; i++)  home_q[i] <= '0;
            count_q <= '0;
            win_q   <= 1'b0;
        end else begin
            free_q <= free_d;
            home_q <= home_d;
            win_q  <= win_d;
            if (commit && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            src_card_q <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= ERR_OK;
            ready_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (move_valid && !load_valid) begin
                    src_q   <= move_src;
                    dst_q   <= move_dst;
                    ready_q <= 1'b0;
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    src_card_q <= fetch_card;
                    state_q    <= S_CHECK;
                end
                S_CHECK: begin
                    done_q  <= 1'b1;
                    ok_q    <= (err_c == ERR_OK);
                    err_q   <= err_c;
                    state_q <= S_COMMIT;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign load_ready = ready_q;
    assign move_ready = ready_q;
    assign done       = done_q;
    assign move_ok    = ok_q;
    assign err_code   = err_q;
    assign move_count = count_q;
    assign win        = win_q;

endmodule

// File: tb/tb_freecell_engine.sv
// tb/tb_freecell_engine.sv - directed self-checking bench for freecell_engine
module tb_freecell_engine;
    import freecell_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [2:0]  load_col = '0;
    logic [5:0]  load_card = '0;
    logic        load_ready;
    logic        move_valid = 1'b0;
    logic [3:0]  move_src = '0;
    logic [3:0]  move_dst = '0;
    logic        move_ready, done, move_ok, win;
    logic [2:0]  err_code;
    logic [15:0] move_count;

    int checks = 0;
    int errors = 0;

    freecell_engine #(.NUM_COLS(8), .COL_DEPTH(20), .NUM_FREE(4), .LOC_W(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_col   (load_col),
        .load_card  (load_card),
        .load_ready (load_ready),
        .move_valid (move_valid),
        .move_src   (move_src),
        .move_dst   (move_dst),
        .move_ready (move_ready),
        .done       (done),
        .move_ok    (move_ok),
        .err_code   (err_code),
        .move_count (move_count),
        .win        (win)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int col, input logic [5:0] card);
        @(negedge clock);
        load_valid = 1'b1;
        load_col   = 3'(col);
        load_card  = card;
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    task automatic move(input int src, input int dst, output logic ok, output logic [2:0] err,
                        output int lat, output logic win_at_done);
        @(negedge clock);
        move_valid = 1'b1;
        move_src   = 4'(src);
        move_dst   = 4'(dst);
        @(posedge clock);
        #1 move_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done) break;
            @(posedge clock);
            lat++;
        end
        check("done_seen", done, 1);
        ok          = move_ok;
        err         = err_code;
        win_at_done = win;
        @(posedge clock);
        #1;
    endtask

    task automatic mv(input string tag, input int src, input int dst,
                      input logic exp_ok, input logic [2:0] exp_err);
        logic ok, w;
        logic [2:0] err;
        int lat;
        move(src, dst, ok, err, lat, w);
        check({tag, "_ok"}, ok, exp_ok);
        check({tag, "_err"}, err, exp_err);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic ok, w;
        logic [2:0] err;
        int lat;

        repeat (2) @(posedge clock);
        #1;
        check("rst_load_ready", load_ready, 1);
        check("rst_move_ready", move_ready, 1);
        check("rst_done", done, 0);
        check("rst_ok", move_ok, 0);
        check("rst_err", err_code, 0);
        check("rst_count", move_count, 0);
        check("rst_win", win, 0);
        @(negedge clock);
        reset_n = 1'b1;

        load(0, 6'h08);
        load(1, 6'h29);
        move(0, 1, ok, err, lat, w);
        check("m01_lat", lat, 3);
        check("m01_ok", ok, 1);
        check("m01_err", err, ERR_OK);
        check("m01_count", move_count, 1);
        check("m01_col1_top", dut.col_top[1], 6'h08);
        check("m01_col0_top", dut.col_top[0], 6'h00);

        load(2, 6'h09);
        mv("rule", 1, 2, 0, ERR_RULE);
        check("rule_count", move_count, 1);
        check("rule_col1_top", dut.col_top[1], 6'h08);
        check("rule_col2_top", dut.col_top[2], 6'h09);

        mv("free_empty", 8, 3, 0, ERR_SRC_EMPTY);
        mv("to_free", 1, 8, 1, ERR_OK);
        check("to_free_count", move_count, 2);
        mv("free_full", 2, 8, 0, ERR_DST_FULL);
        mv("same", 3, 3, 0, ERR_SAME);
        mv("home_src", 12, 0, 0, ERR_BAD_LOC);
        mv("col_empty", 0, 2, 0, ERR_SRC_EMPTY);
        check("rej_count", move_count, 2);

        pulse_reset();
        check("rst2_count", move_count, 0);
        for (int s = 0; s < 4; s++)
            for (int r = 13; r >= 1; r--) begin
                logic [5:0] c;
                c = {2'(s), 4'(r)};
                load(s, c);
            end

        for (int r = 1; r <= 13; r++) begin
            move(0, 12, ok, err, lat, w);
            check("home_h_ok", ok, 1);
        end
        check("home_h_rank", dut.home_q[0], 13);
        check("home_h_count", move_count, 13);
        check("home_h_win", win, 0);

        load(4, 6'h01);
        mv("home_full", 4, 12, 0, ERR_RULE);
        mv("home_col0_empty", 0, 12, 0, ERR_SRC_EMPTY);
        mv("wrong_suit", 1, 12, 0, ERR_RULE);

        for (int s = 1; s < 4; s++)
            for (int r = 1; r <= 13; r++) begin
                move(s, 12 + s, ok, err, lat, w);
                check("home_ok", ok, 1);
                if (s == 3 && r == 13) begin
                    check("win_at_done", w, 0);
                    check("win_after_done", win, 1);
                end
            end
        check("all_count", move_count, 52);

        mv("post_win", 4, 8, 1, ERR_OK);
        check("post_win_count", move_count, 53);
        check("win_sticky", win, 1);

        load(4, 6'h08);
        load(5, 6'h29);
        @(negedge clock);
        move_valid = 1'b1;
        move_src   = 4'd4;
        move_dst   = 4'd5;
        @(posedge clock);
        #1 move_valid = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_done", done, 0);
        check("mid_rst_ready", move_ready, 1);
        check("mid_rst_load_ready", load_ready, 1);
        check("mid_rst_ok", move_ok, 0);
        check("mid_rst_err", err_code, 0);
        check("mid_rst_count", move_count, 0);
        check("mid_rst_win", win, 0);
        check("mid_rst_col4", dut.col_top[4], 0);
        check("mid_rst_col5", dut.col_top[5], 0);
        check("mid_rst_home", dut.home_q[3], 0);
        @(negedge clock);
        reset_n = 1'b1;
        mv("after_rst", 4, 5, 0, ERR_SRC_EMPTY);
        check("after_rst_count", move_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
